mem_port_arbiter: RTL

- Shares one single-port, fixed-latency, 32-bit word RAM between the fetch port (IF) and the load/store port (LS).
- Replaces the separate program and data memories with a unified memory.
- Sits between fetch_stage/mem_stage and the RAM macro.
- Issues at most one access per cycle and routes each read response back to its owner.
- Fetch responses can be killed on branch flush.

---
 rtl/mem_port_arbiter_pkg.sv | 19 +
 rtl/arb_tag_pipe.sv | 47 ++++
 rtl/mem_port_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default parameters for the unified-memory port arbiter.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_port_arbiter_pkg;

    localparam int MEM_ARB_LATENCY      = 2;
    localparam int MEM_ARB_STARVE_LIMIT = 4;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_e;

    typedef struct packed {
        logic       valid;
        arb_owner_e owner;
    } arb_tag_t;

endpackage

// File: rtl/arb_tag_pipe.sv
// Tag shift register that follows each RAM read to its owner, with per-owner kill.
// Latency: a tag pushed in cycle t appears on tail in cycle t+DEPTH.
// Backpressure: none; shifts every cycle, kill also masks the tail combinationally.
module arb_tag_pipe
    import mem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = MEM_ARB_LATENCY
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       push_vld,
    input  arb_owner_e push_owner,
    input  logic       kill_vld,
    input  arb_owner_e kill_owner,
    output arb_tag_t   tail
);

    arb_tag_t [DEPTH-1:0] stage_q;
    arb_tag_t [DEPTH-1:0] killed;
    arb_tag_t             push_tag;

    // The push in a kill cycle is never masked: it belongs to a new, accepted access.
    always_comb begin
        push_tag.valid = push_vld;
        push_tag.owner = push_owner;
        killed         = stage_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_vld && (stage_q[i].owner == kill_owner)) begin
                killed[i].valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= killed[i-1];
            end
        end
    end

    assign tail = killed[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency RAM between fetch (IF) and load/store (LS); optional MEM_ARB_PERF_EN counters.
// Latency: grant is combinational; read data returns MEM_LATENCY cycles after grant.
// Backpressure: LS wins conflicts until IF has lost STARVE_LIMIT times; RAM never stalls.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int MEM_LATENCY  = MEM_ARB_LATENCY,
    parameter int STARVE_LIMIT = MEM_ARB_STARVE_LIMIT,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
`ifdef MEM_ARB_PERF_EN
    output logic [31:0]       perf_if_grants,
    output logic [31:0]       perf_ls_grants,
    output logic [31:0]       perf_conflicts,
`endif
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              if_flush,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [3:0]        ls_be,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic              ls_gnt,
    output logic              ls_rvalid,
    output logic [31:0]       ls_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam int            SW         = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    logic [SW-1:0] starve_cnt;
    logic          if_prio;
    logic          rd_issue;
    arb_owner_e    push_owner;
    arb_tag_t      tag_tail;

    // Grants are gated by reset so nothing is issued while reset_n is low.
    always_comb begin
        if_prio = (starve_cnt == STARVE_MAX);
        if_gnt  = reset_n & if_req & (~ls_req | if_prio);
        ls_gnt  = reset_n & ls_req & ~(if_req & if_prio);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (if_gnt) begin
            starve_cnt <= '0;
        end else if (if_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
        if (if_gnt) begin
            mem_req  = 1'b1;
            mem_be   = 4'hF;
            mem_addr = if_addr;
        end else if (ls_gnt) begin
            mem_req   = 1'b1;
            mem_we    = ls_we;
            mem_be    = ls_be;
            mem_addr  = ls_addr;
            mem_wdata = ls_wdata;
        end
    end

    assign rd_issue   = mem_req & ~mem_we;
    assign push_owner = if_gnt ? OWN_IF : OWN_LS;

    arb_tag_pipe #(
        .DEPTH(MEM_LATENCY)
    ) u_tag_pipe (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_vld  (rd_issue),
        .push_owner(push_owner),
        .kill_vld  (if_flush),
        .kill_owner(OWN_IF),
        .tail      (tag_tail)
    );

    always_comb begin
        if_rvalid = tag_tail.valid & (tag_tail.owner == OWN_IF);
        ls_rvalid = tag_tail.valid & (tag_tail.owner == OWN_LS);
        if_rdata  = if_rvalid ? mem_rdata : 32'h0;
        ls_rdata  = ls_rvalid ? mem_rdata : 32'h0;
    end

`ifdef MEM_ARB_PERF_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_if_grants <= 32'h0;
            perf_ls_grants <= 32'h0;
            perf_conflicts <= 32'h0;
        end else begin
            if (if_gnt) begin
                perf_if_grants <= perf_if_grants + 32'd1;
            end
            if (ls_gnt) begin
                perf_ls_grants <= perf_ls_grants + 32'd1;
            end
            if (if_req && ls_req) begin
                perf_conflicts <= perf_conflicts + 32'd1;
            end
        end
    end
`endif

endmodule
